// File: rtl/ifpad_ring.sv
// rtl/ifpad_ring.sv - sliding-window pixel ring buffer with window reuse
//
// Buffers an input pixel stream in a circular store and replays a window of
// W = winLen+1 entries P = reuse+1 times. It then retires `stride` entries
// and moves on to the next window. Writes stay open while a window is being
// replayed, so the next window is prefetched.
//
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_cont_reset         synchronous soft reset (has priority over stall)
//   i_cont_stall         freezes all state
//   i_cont_start         start pulse, sampled in IDLE
//   i_cont_winLen        window length minus one
//   i_cont_stride        entries retired per window advance (1..W)
//   i_cont_reuse         window passes minus one
//   i_cont_lastWin       current window is the final one
//   o_cont_done          pulse at the end of the final window
//   i_ipix_*/o_ipix_ready  input pixel stream (data + zero flag)
//   o_opix_*/i_opix_ready  output pixel stream (data + zero flag)
module ifpad_ring #(
  parameter  int DWd     = 16,
  parameter  int Depth   = 16,
  parameter  int ReuseWd = 4,
  localparam int AddrWd  = $clog2(Depth),
  localparam int CntWd   = $clog2(Depth) + 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cont_reset,
  input  logic               i_cont_stall,
  input  logic               i_cont_start,
  input  logic [AddrWd-1:0]  i_cont_winLen,
  input  logic [AddrWd-1:0]  i_cont_stride,
  input  logic [ReuseWd-1:0] i_cont_reuse,
  input  logic               i_cont_lastWin,
  output logic               o_cont_done,
  input  logic               i_ipix_valid,
  input  logic [DWd-1:0]     i_ipix_data,
  input  logic               i_ipix_zero,
  output logic               o_ipix_ready,
  output logic               o_opix_valid,
  output logic [DWd-1:0]     o_opix_data,
  output logic               o_opix_zero,
  input  logic               i_opix_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_LOOP  = 2'd2,
    S_SLIDE = 2'd3
  } state_e;

  state_e             state_q;
  logic [AddrWd-1:0]  wp_q;
  logic [AddrWd-1:0]  bp_q;
  logic [AddrWd-1:0]  off_q;
  logic [ReuseWd-1:0] pass_q;
  logic [CntWd-1:0]   cnt_q;
  logic [CntWd-1:0]   cnt_d;
  logic [AddrWd-1:0]  winlen_q;
  logic [AddrWd-1:0]  stride_q;
  logic [ReuseWd-1:0] reuse_q;

  logic [DWd-1:0]     data_q [Depth];
  logic [Depth-1:0]   zero_q;

  logic               ce;
  logic               wr_en;
  logic               rd_en;
  logic [AddrWd-1:0]  rd_addr;
  logic [CntWd-1:0]   win_w;
  logic [CntWd-1:0]   cnt_inc;

  assign ce           = !i_cont_reset && !i_cont_stall;
  assign o_ipix_ready = ce && (state_q != S_IDLE) && (cnt_q < CntWd'(Depth));
  assign wr_en        = i_ipix_valid && o_ipix_ready;
  assign o_opix_valid = ce && (state_q == S_LOOP);
  assign rd_en        = o_opix_valid && i_opix_ready;
  assign rd_addr      = bp_q + off_q;  // natural AddrWd wrap gives mod Depth
  assign o_opix_data  = data_q[rd_addr];
  assign o_opix_zero  = zero_q[rd_addr];
  assign o_cont_done  = ce && (state_q == S_SLIDE) && i_cont_lastWin;
  assign win_w        = {1'b0, winlen_q} + CntWd'(1);

  // Occupancy: +1 per write, -stride in SLIDE. Clamped at 0 so an illegal
  // stride cannot wrap the counter.
  always_comb begin
    cnt_inc = cnt_q + CntWd'(wr_en);
    cnt_d   = cnt_inc;
    if (state_q == S_SLIDE) begin
      if (cnt_inc >= {1'b0, stride_q}) cnt_d = cnt_inc - {1'b0, stride_q};
      else                             cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_IDLE;
      wp_q     <= '0;
      bp_q     <= '0;
      off_q    <= '0;
      pass_q   <= '0;
      cnt_q    <= '0;
      winlen_q <= '0;
      stride_q <= '0;
      reuse_q  <= '0;
    end else if (i_cont_reset) begin
      state_q  <= S_IDLE;
      wp_q     <= '0;
      bp_q     <= '0;
      off_q    <= '0;
      pass_q   <= '0;
      cnt_q    <= '0;
      winlen_q <= '0;
      stride_q <= '0;
      reuse_q  <= '0;
    end else if (ce) begin
      if (wr_en) wp_q <= wp_q + AddrWd'(1);
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (i_cont_start) begin
            state_q  <= S_FILL;
            winlen_q <= i_cont_winLen;
            stride_q <= i_cont_stride;
            reuse_q  <= i_cont_reuse;
            wp_q     <= '0;
            bp_q     <= '0;
            off_q    <= '0;
            pass_q   <= '0;
            cnt_q    <= '0;
          end
        end
        S_FILL: begin
          // Compare on the registered count: LOOP starts two cycles after
          // the W-th write at the earliest.
          if (cnt_q >= win_w) begin
            state_q <= S_LOOP;
            off_q   <= '0;
            pass_q  <= '0;
          end
        end
        S_LOOP: begin
          if (rd_en) begin
            if (off_q == winlen_q) begin
              off_q <= '0;
              if (pass_q == reuse_q) begin
                pass_q  <= '0;
                state_q <= S_SLIDE;
              end else begin
                pass_q <= pass_q + ReuseWd'(1);
              end
            end else begin
              off_q <= off_q + AddrWd'(1);
            end
          end
        end
        S_SLIDE: begin
          bp_q    <= bp_q + stride_q;
          state_q <= i_cont_lastWin ? S_IDLE : S_FILL;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Zero flags reset to 1 so never-written entries read back as zero pixels.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)           zero_q        <= '1;
    else if (i_cont_reset) zero_q        <= '1;
    else if (wr_en)        zero_q[wp_q]  <= i_ipix_zero;
  end

  // Pixel data is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (wr_en) data_q[wp_q] <= i_ipix_data;
  end

endmodule
